// File: rtl/spw_ulight_fifo_bridge.sv
`default_nettype none
// ============================================================================
// Module   : spw_ulight_fifo_bridge
// Purpose  : Avalon-MM slave bridging up to four SpaceWire ulight links.
//            Each channel has a TX FIFO, an RX FIFO, a time-code transmit
//            handshake, a time-code receive latch, sticky error flags and
//            link control bits.
// Ports    : clk_clk / reset_reset      clock, synchronous active-high reset
//            avs_*                      register bus, 4 words per channel,
//                                       read data valid one cycle after read
//            data_tx_to_w/data_en_to_w  TX characters to the links (9b each)
//            data_rx_r/data_rx_ready    RX characters from the links
//            timec_*                    time-code TX handshake and RX strobe
//            fsm_info/credit_error_rx   link status inputs
//            link_start/link_disable/auto_start  link control outputs
// Revision : 1.0 - initial release
// ============================================================================
module spw_ulight_fifo_bridge #(
    parameter int CHANNELS = 2,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic [$clog2(CHANNELS)+1:0]   avs_address,
    input  logic                          avs_write,
    input  logic                          avs_read,
    input  logic [31:0]                   avs_writedata,
    output logic [31:0]                   avs_readdata,
    output logic [CHANNELS*9-1:0]         data_tx_to_w,
    output logic [CHANNELS-1:0]           data_en_to_w,
    input  logic [CHANNELS-1:0]           data_tx_ready,
    input  logic [CHANNELS*9-1:0]         data_rx_r,
    input  logic [CHANNELS-1:0]           data_rx_ready,
    output logic [CHANNELS*8-1:0]         timec_tx_to_w,
    output logic [CHANNELS-1:0]           timec_en_to_tx,
    input  logic [CHANNELS-1:0]           timec_tx_ready,
    input  logic [CHANNELS*8-1:0]         timec_rx_r,
    input  logic [CHANNELS-1:0]           timec_rx_ready,
    input  logic [CHANNELS*6-1:0]         fsm_info,
    input  logic [CHANNELS-1:0]           credit_error_rx,
    output logic [CHANNELS-1:0]           link_start,
    output logic [CHANNELS-1:0]           link_disable,
    output logic [CHANNELS-1:0]           auto_start
);

    localparam int       c_tx_pw   = $clog2(TX_DEPTH);
    localparam int       c_rx_pw   = $clog2(RX_DEPTH);
    localparam bit [0:0] c_tc_idle = 1'b0;
    localparam bit [0:0] c_tc_busy = 1'b1;

    logic [1:0]          w_off;
    logic [2:0]          w_chan;
    logic                w_chan_ok;
    logic [CHANNELS-1:0] w_sel;
    logic [31:0]         w_rd_status [CHANNELS];
    logic [31:0]         w_rd_rx     [CHANNELS];
    logic [31:0]         w_rd_ctrl   [CHANNELS];
    logic [31:0]         w_rd_data;
    logic [31:0]         r_readdata;
    logic                w_unused;

    // Upper address bits select the channel; a 3-bit view covers all widths.
    assign w_off     = avs_address[1:0];
    assign w_chan    = 3'(avs_address >> 2);
    assign w_chan_ok = (w_chan < 3'(CHANNELS));
    assign w_unused  = ^avs_writedata[31:17];

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [8:0]         r_tx_mem [TX_DEPTH];
            logic [8:0]         r_rx_mem [RX_DEPTH];
            logic [c_tx_pw-1:0] r_tx_wp, r_tx_rp;
            logic [c_rx_pw-1:0] r_rx_wp, r_rx_rp;
            logic [c_tx_pw:0]   r_tx_cnt;
            logic [c_rx_pw:0]   r_rx_cnt;
            logic               r_tx_ovf, r_rx_ovf, r_credit_err;
            logic               r_tc_rx_valid;
            logic [7:0]         r_tc_rx_val;
            logic [0:0]         r_tc_state;
            logic [7:0]         r_tc_tx_val;
            logic [2:0]         r_ctrl;

            logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
            logic w_ctrl_wr, w_ctrl_rd, w_flush, w_clr_sticky, w_tc_load;
            logic w_tx_wr, w_tx_push, w_tx_pop;
            logic w_rx_push, w_rx_drop, w_rx_pop;
            logic w_tc_busy;

            assign w_sel[c] = w_chan_ok && (w_chan == 3'(c));

            assign w_tx_full  = (r_tx_cnt == (c_tx_pw+1)'(TX_DEPTH));
            assign w_tx_empty = (r_tx_cnt == '0);
            assign w_rx_full  = (r_rx_cnt == (c_rx_pw+1)'(RX_DEPTH));
            assign w_rx_empty = (r_rx_cnt == '0);
            assign w_tc_busy  = (r_tc_state == c_tc_busy);

            assign w_ctrl_wr    = avs_write && w_sel[c] && (w_off == 2'd3);
            assign w_ctrl_rd    = avs_read  && w_sel[c] && (w_off == 2'd3);
            assign w_flush      = w_ctrl_wr && avs_writedata[3];
            assign w_clr_sticky = w_ctrl_wr && avs_writedata[4];
            assign w_tc_load    = w_ctrl_wr && avs_writedata[16] && !w_tc_busy;

            // A flush on this channel overrides any same-cycle push or pop.
            assign w_tx_wr   = avs_write && w_sel[c] && (w_off == 2'd0);
            assign w_tx_push = w_tx_wr && !w_tx_full && !w_flush;
            assign w_tx_pop  = !w_tx_empty && data_tx_ready[c] && !w_flush;
            assign w_rx_push = data_rx_ready[c] && !w_rx_full && !w_flush;
            assign w_rx_drop = data_rx_ready[c] && w_rx_full && !w_flush;
            assign w_rx_pop  = avs_read && w_sel[c] && (w_off == 2'd1) &&
                               !w_rx_empty && !w_flush;

            // Storage carries no reset; the counts define what is valid.
            always_ff @(posedge clk_clk) begin
                if (w_tx_push) r_tx_mem[r_tx_wp] <= avs_writedata[8:0];
                if (w_rx_push) r_rx_mem[r_rx_wp] <= data_rx_r[c*9 +: 9];
            end

            always_ff @(posedge clk_clk) begin
                if (reset_reset || w_flush) begin
                    r_tx_wp  <= '0;
                    r_tx_rp  <= '0;
                    r_tx_cnt <= '0;
                    r_rx_wp  <= '0;
                    r_rx_rp  <= '0;
                    r_rx_cnt <= '0;
                end else begin
                    if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
                    if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
                    if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
                    else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
                    if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
                    if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
                    if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
                    else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
                end
            end

            // Sticky flags: a same-cycle set beats the clear.
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    r_tx_ovf      <= 1'b0;
                    r_rx_ovf      <= 1'b0;
                    r_credit_err  <= 1'b0;
                    r_tc_rx_valid <= 1'b0;
                    r_tc_rx_val   <= '0;
                    r_ctrl        <= '0;
                end else begin
                    if (w_tx_wr && w_tx_full) r_tx_ovf <= 1'b1;
                    else if (w_clr_sticky)    r_tx_ovf <= 1'b0;
                    if (w_rx_drop)            r_rx_ovf <= 1'b1;
                    else if (w_clr_sticky)    r_rx_ovf <= 1'b0;
                    if (credit_error_rx[c])   r_credit_err <= 1'b1;
                    else if (w_clr_sticky)    r_credit_err <= 1'b0;
                    if (timec_rx_ready[c]) begin
                        r_tc_rx_valid <= 1'b1;
                        r_tc_rx_val   <= timec_rx_r[c*8 +: 8];
                    end else if (w_ctrl_rd) begin
                        r_tc_rx_valid <= 1'b0;
                    end
                    if (w_ctrl_wr) r_ctrl <= avs_writedata[2:0];
                end
            end

            // Time-code transmit handshake.
            always_ff @(posedge clk_clk) begin
                if (reset_reset) begin
                    r_tc_state  <= c_tc_idle;
                    r_tc_tx_val <= '0;
                end else begin
                    case (r_tc_state)
                        c_tc_idle: begin
                            if (w_tc_load) begin
                                r_tc_state  <= c_tc_busy;
                                r_tc_tx_val <= avs_writedata[15:8];
                            end
                        end
                        default: begin
                            if (timec_tx_ready[c]) r_tc_state <= c_tc_idle;
                        end
                    endcase
                end
            end

            // Outputs are forced to zero when nothing is pending.
            assign data_en_to_w[c]          = !w_tx_empty;
            assign data_tx_to_w[c*9 +: 9]   = w_tx_empty ? 9'd0 : r_tx_mem[r_tx_rp];
            assign timec_en_to_tx[c]        = w_tc_busy;
            assign timec_tx_to_w[c*8 +: 8]  = w_tc_busy ? r_tc_tx_val : 8'd0;
            assign link_start[c]            = r_ctrl[0];
            assign link_disable[c]          = r_ctrl[1];
            assign auto_start[c]            = r_ctrl[2];

            assign w_rd_status[c] = {1'b0, 7'(r_tx_cnt), 1'b0, 7'(r_rx_cnt), 2'b00,
                                     w_tc_busy, r_tc_rx_valid, r_credit_err,
                                     r_tx_ovf, r_rx_ovf, w_rx_empty, w_tx_empty,
                                     w_tx_full, fsm_info[c*6 +: 6]};
            assign w_rd_rx[c]     = w_rx_empty ? 32'd0 :
                                    {1'b1, 22'd0, r_rx_mem[r_rx_rp]};
            assign w_rd_ctrl[c]   = {16'd0, r_tc_rx_val, 5'd0, r_ctrl};
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_sel[c]) begin
                case (w_off)
                    2'd1:    w_rd_data = w_rd_rx[c];
                    2'd2:    w_rd_data = w_rd_status[c];
                    2'd3:    w_rd_data = w_rd_ctrl[c];
                    default: w_rd_data = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset)   r_readdata <= '0;
        else if (avs_read) r_readdata <= w_rd_data;
        else               r_readdata <= '0;
    end

    assign avs_readdata = r_readdata;

endmodule
`default_nettype wire
